// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - AXI4-Lite register slave shared types, response codes and strobe helper
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axil_ifc.sv
// rtl/axil_ifc.sv - AXI4-Lite channel bundle with master and slave views
interface axil_ifc #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_regfile.sv
// rtl/axil_regfile.sv - 32-bit register storage with byte-masked write port and update pulses
module axil_regfile
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic [31:0]            wr_data_i,
  input  logic [3:0]             wr_strb_i,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output logic [31:0]            rd_data_o,
  output logic [NUM_REGS*32-1:0] regs_o,
  output logic [NUM_REGS-1:0]    wr_pulse_o
);

  logic [31:0]         mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q;
  logic [31:0]         mask;

  assign mask = strb_mask(wr_strb_i);

  // An all-zero strobe is a legal no-op: nothing changes, so no pulse either.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (wr_en_i && (wr_strb_i != 4'b0000)) begin
        mem_q[wr_idx_i]   <= (mem_q[wr_idx_i] & ~mask) | (wr_data_i & mask);
        pulse_q[wr_idx_i] <= 1'b1;
      end
    end
  end

  assign rd_data_o  = mem_q[rd_idx_i];
  assign wr_pulse_o = pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[32*g +: 32] = mem_q[g];
  end

endmodule

// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite responder over a bank of control/status registers
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axil_ifc.slave                         axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam logic [WIDX_W-1:0] NREGS = WIDX_W'(NUM_REGS);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [31:0]           rdata_q, rd_data;
  logic                  awready, wready, arready, bvalid, rvalid, wr_en;
  logic                  aw_hs, w_hs, ar_hs;
  logic [WIDX_W-1:0]     aw_idx, ar_idx;
  logic                  aw_in_range, ar_in_range;
  logic                  unused_bits;

  assign aw_idx      = awaddr_q[ADDR_WIDTH-1:2];
  assign ar_idx      = axil.araddr[ADDR_WIDTH-1:2];
  assign aw_in_range = aw_idx < NREGS;
  assign ar_in_range = ar_idx < NREGS;
  assign aw_hs       = axil.awvalid & awready;
  assign w_hs        = axil.wvalid & wready;
  assign ar_hs       = axil.arvalid & arready;
  assign unused_bits = ^{axil.awprot, axil.arprot, awaddr_q[1:0], axil.araddr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  // Commit is entered on the edge that completes the AW/W pair, giving one-cycle write latency.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE:   if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) wr_state_d = WR_COMMIT;
      WR_COMMIT: wr_state_d = WR_RESP;
      WR_RESP:   if (axil.bready) wr_state_d = WR_IDLE;
      default:   wr_state_d = WR_IDLE;
    endcase
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (axil.arvalid) rd_state_d = RD_RESP;
      RD_RESP: if (axil.rready) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    awready = (wr_state_q == WR_IDLE) && !aw_held_q;
    wready  = (wr_state_q == WR_IDLE) && !w_held_q;
    bvalid  = (wr_state_q == WR_RESP);
    wr_en   = (wr_state_q == WR_COMMIT) && aw_in_range;
    arready = (rd_state_q == RD_IDLE);
    rvalid  = (rd_state_q == RD_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= axil.awaddr;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= axil.wdata;
        wstrb_q  <= axil.wstrb;
      end
      if (wr_state_q == WR_COMMIT) begin
        bresp_q <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if ((wr_state_q == WR_RESP) && axil.bready) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
      if (ar_hs) begin
        rdata_q <= ar_in_range ? rd_data : 32'h0;
        rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign axil.awready = awready;
  assign axil.wready  = wready;
  assign axil.bvalid  = bvalid;
  assign axil.bresp   = bresp_q;
  assign axil.arready = arready;
  assign axil.rvalid  = rvalid;
  assign axil.rdata   = rdata_q;
  assign axil.rresp   = rresp_q;

  axil_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_idx_i   (aw_idx[IDX_W-1:0]),
    .wr_data_i  (wdata_q),
    .wr_strb_i  (wstrb_q),
    .rd_idx_i   (ar_idx[IDX_W-1:0]),
    .rd_data_o  (rd_data),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb/tb_axil_reg_slave.sv - directed and randomized self-checking bench for axil_reg_slave
module tb_axil_reg_slave;

  localparam int NREG = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREG*32-1:0] regs;
  logic [NREG-1:0]   pulse;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [NREG];

  axil_ifc #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) bus ();

  axil_reg_slave #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .NUM_REGS(NREG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axil       (bus),
    .regs_o     (regs),
    .wr_pulse_o (pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return regs[32*i +: 32];
  endfunction

  // Reference: byte-lane update of an array, address decoded arithmetically.
  task automatic model_write(input logic [12:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [NREG-1:0] pv);
    int idx;
    idx = int'(addr) / 4;
    pv = '0;
    if (idx < NREG) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      resp = 2'b00;
      if (strb != 4'h0) pv[idx] = 1'b1;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic do_write(input logic [12:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly,
                          output int lat, output logic [1:0] resp, output logic [NREG-1:0] pv,
                          output logic [NREG-1:0] pv_after);
    int  cyc;
    bit  aw_done, w_done, aw_fire, w_fire;
    cyc = 0; aw_done = 0; w_done = 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      bus.awvalid = !aw_done && (cyc >= aw_dly);
      bus.wvalid  = !w_done && (cyc >= w_dly);
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      tick();
      cyc++;
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
    end
    bus.awvalid = 0; bus.wvalid = 0;
    lat = 0;
    while (!bus.bvalid && lat < 20) begin
      tick();
      lat++;
    end
    resp = bus.bresp;
    pv = pulse;
    bus.bready = 1;
    tick();
    bus.bready = 0;
    pv_after = pulse;
  endtask

  task automatic do_read(input logic [12:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output int lat);
    int w;
    w = 0;
    bus.araddr = addr; bus.arvalid = 1;
    while (!bus.arready && w < 20) begin
      tick();
      w++;
    end
    tick();
    bus.arvalid = 0;
    lat = 0;
    while (!bus.rvalid && lat < 20) begin
      tick();
      lat++;
    end
    data = bus.rdata; resp = bus.rresp;
    bus.rready = 1;
    tick();
    bus.rready = 0;
  endtask

  initial begin
    int lat;
    logic [1:0] resp, eresp;
    logic [31:0] rd;
    logic [NREG-1:0] pv, pv2, epv;
    logic [31:0] hold_rdata;
    logic [1:0]  hold_bresp;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    check("rst_awready", bus.awready, 1);
    check("rst_wready", bus.wready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_pulse", pulse, 0);
    for (int i = 0; i < NREG; i++) check("rst_reg", reg_of(i), 0);
    do_read(13'h0, rd, resp, lat);
    check("rst_read_data", rd, 0);
    check("rst_read_resp", resp, 2'b00);

    // Full write, same-cycle AW/W
    do_write(13'h8, 32'hDEADBEEF, 4'hF, 0, 0, lat, resp, pv, pv2);
    model_write(13'h8, 32'hDEADBEEF, 4'hF, eresp, epv);
    check("full_lat", lat, 1);
    check("full_resp", resp, eresp);
    check("full_pulse", pv, epv);
    check("full_pulse_off", pv2, 0);
    do_read(13'h8, rd, resp, lat);
    check("full_read", rd, 32'hDEADBEEF);
    check("full_read_lat", lat, 0);

    // Byte strobes with W leading AW by 3 cycles
    do_write(13'h8, 32'h11223344, 4'b0101, 3, 0, lat, resp, pv, pv2);
    model_write(13'h8, 32'h11223344, 4'b0101, eresp, epv);
    check("skew_lat", lat, 1);
    check("skew_reg2", reg_of(2), 32'hDE22BE44);
    check("skew_model", reg_of(2), model[2]);

    // Out of range
    do_write(13'h40, 32'hCAFEF00D, 4'hF, 0, 0, lat, resp, pv, pv2);
    model_write(13'h40, 32'hCAFEF00D, 4'hF, eresp, epv);
    check("oor_bresp", resp, 2'b10);
    check("oor_pulse", pv, 0);
    for (int i = 0; i < NREG; i++) check("oor_regs", reg_of(i), model[i]);
    do_read(13'h40, rd, resp, lat);
    check("oor_rresp", resp, 2'b10);
    check("oor_rdata", rd, 0);

    // Backpressure on both response channels
    bus.awaddr = 13'hC; bus.wdata = 32'h0000ABCD; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; bus.araddr = 13'h9; bus.arvalid = 1;
    tick();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    tick();
    model_write(13'hC, 32'h0000ABCD, 4'hF, eresp, epv);
    hold_bresp = bus.bresp; hold_rdata = bus.rdata;
    check("bp_rdata", hold_rdata, model[2]);
    for (int c = 0; c < 5; c++) begin
      check("bp_bvalid", bus.bvalid, 1);
      check("bp_bresp", bus.bresp, 2'b00);
      check("bp_rvalid", bus.rvalid, 1);
      check("bp_rdata_hold", bus.rdata, hold_rdata);
      check("bp_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
      tick();
    end
    bus.bready = 1; bus.rready = 1;
    tick();
    bus.bready = 0; bus.rready = 0;
    check("bp_b_done", bus.bvalid, 0);
    check("bp_r_done", bus.rvalid, 0);
    check("bp_reg3", reg_of(3), model[3]);

    // Read on the commit edge sees the old value
    do_write(13'hC, 32'h5, 4'hF, 0, 0, lat, resp, pv, pv2);
    model_write(13'hC, 32'h5, 4'hF, eresp, epv);
    bus.awaddr = 13'hC; bus.wdata = 32'h7; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    bus.araddr = 13'hC; bus.arvalid = 1;
    tick();
    bus.arvalid = 0;
    model_write(13'hC, 32'h7, 4'hF, eresp, epv);
    check("conc_rvalid", bus.rvalid, 1);
    check("conc_rdata_old", bus.rdata, 32'h5);
    check("conc_reg3_new", reg_of(3), 32'h7);
    bus.rready = 1;
    tick();
    bus.rready = 0;
    check("conc_bvalid_held", bus.bvalid, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    check("mid_rst_bvalid", bus.bvalid, 0);
    check("mid_rst_awready", bus.awready, 1);
    for (int i = 0; i < NREG; i++) check("mid_rst_regs", reg_of(i), 0);

    // Randomized writes and reads against the array model
    for (int n = 0; n < 40; n++) begin
      logic [12:0] addr;
      logic [31:0] data, exp_rd;
      logic [3:0]  strb;
      int idx;
      addr = 13'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      data = $urandom;
      strb = 4'($urandom);
      do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), lat, resp, pv, pv2);
      model_write(addr, data, strb, eresp, epv);
      check("rnd_wlat", lat, 1);
      check("rnd_bresp", resp, eresp);
      check("rnd_pulse", pv, epv);
      addr = 13'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      idx = int'(addr) / 4;
      exp_rd = (idx < NREG) ? model[idx] : 32'h0;
      do_read(addr, rd, resp, lat);
      check("rnd_rdata", rd, exp_rd);
      check("rnd_rresp", resp, (idx < NREG) ? 2'b00 : 2'b10);
    end
    for (int i = 0; i < NREG; i++) check("rnd_final_regs", reg_of(i), model[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
# axil_reg_slave

AXI4-Lite responder that terminates the `axil_ifc.slave` modport and implements a bank of 32-bit control/status registers. It is the target-side counterpart of the test bench's clocking-block driver. It gives CGRA test apps and top-level glue a memory-mapped register file with byte strobes, OKAY/SLVERR responses and one outstanding transaction per direction.

## Interface
Parameters:
- ADDR_WIDTH, 13, AXI address width; must match the bound `axil_ifc`.
- DATA_WIDTH, 32, data width; only 32 is supported.
- NUM_REGS, 16, number of registers; word index `addr[ADDR_WIDTH-1:2]` must be below NUM_REGS.

Ports:
- clk  input  1  clock; all logic on the posedge.
- rst_n  input  1  reset; synchronous, active-low.
- axil  interface  axil_ifc.slave  AXI4-Lite channels; arprot/awprot are ignored.
- regs_o  output  NUM_REGS*DATA_WIDTH  flat register contents; reg i occupies bits [32i+31:32i].
- wr_pulse_o  output  NUM_REGS  one-cycle pulse for a reg on the cycle after its update commits.

## Operation
- Write path, state machine WR_IDLE → WR_COMMIT → WR_RESP:
  - WR_IDLE: awready = !aw_held; wready = !w_held. AW and W are accepted independently, in either order or in the same cycle, and each is latched (awaddr; wdata and wstrb).
  - When both are held, the next edge enters WR_COMMIT.
  - WR_COMMIT (1 cycle): if the index is in range, each byte b with wstrb[b]=1 is written and bresp=OKAY. Otherwise nothing is written and bresp=SLVERR (2'b10). bvalid is set on the same edge, and the state moves to WR_RESP.
  - WR_RESP: bvalid is held stable with bresp until bready. On the handshake edge, bvalid drops, the held flags clear and the state returns to WR_IDLE. awready and wready are 0 throughout WR_COMMIT and WR_RESP.
  - wstrb=0 with an in-range address: no change, OKAY, no wr_pulse_o.
- Read path, state machine RD_IDLE → RD_RESP:
  - arready = !rvalid.
  - On the AR handshake edge, rdata is captured from the current register contents, which is the pre-write value if a commit happens on the same edge. rresp=OKAY, or SLVERR with rdata=0 if out of range. rvalid is set.
  - rdata and rresp are held stable until rready. On the handshake edge, rvalid drops.
- Read and write paths are fully independent; neither stalls the other.
- Address bits [1:0] are ignored, so unaligned addresses access the containing word.

## Timing
- Reset values (applied while rst_n=0 at the edge): all registers 0; awready=1, wready=1, arready=1; bvalid=0, rvalid=0; bresp=0, rresp=0, rdata=0; wr_pulse_o=0; both FSMs idle with held flags cleared.
- Write latency:
  - AW and W handshake at edge 0: the register update and bvalid=1 take effect at edge 1.
  - If W arrives k cycles after AW, bvalid occurs 1 cycle after the later handshake.
- wr_pulse_o is high for exactly the cycle following the commit edge.
- Read latency: AR handshake at edge 0 → rvalid=1 after edge 0. With rready held high, one read completes every 2 cycles.
- Back-to-back writes: one write completes every 3 cycles with bready held high (accept, commit, response).
- A reset in the middle of a transaction abandons it without a response. The master must restart after reset.
- Valid/ready compliance:
  - Outputs never depend combinationally on the valid inputs.
  - The slave never waits for awvalid+wvalid together before asserting a ready.

## Structure
- Package `axil_pkg`:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Enum typedefs `wr_state_e` {WR_IDLE, WR_COMMIT, WR_RESP} and `rd_state_e` {RD_IDLE, RD_RESP}.
  - A `strb_mask` function that expands wstrb into a 32-bit mask.
- One sub-module: `axil_regfile`, which holds the NUM_REGS×32 storage. It takes a write port (index, data, strb, en), provides a combinational read of any index, outputs regs_o, and generates wr_pulse_o.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n=0 for 2 cycles, then release.
  - Required: awready/wready/arready=1, bvalid/rvalid=0, regs_o=0, and a read of 0x0 returns 0 with OKAY.
- Full write and readback:
  - Stimulus: write 0xDEADBEEF to 0x8 with wstrb=4'hF, AW and W in the same cycle.
  - Required: bvalid 1 cycle later with OKAY, wr_pulse_o[2] pulses, and a read of 0x8 returns 0xDEADBEEF.
- Byte strobe and channel skew:
  - Stimulus: with reg 2 holding 0xDEADBEEF, send W (0x11223344, wstrb=4'b0101) 3 cycles before AW (0x8).
  - Required: reg 2 becomes 0xDE22BE44 and bvalid appears 1 cycle after the AW handshake.
- Out-of-range access:
  - Stimulus: NUM_REGS=16; write to 0x40, then read 0x40.
  - Required: bresp=SLVERR with no register changed and no pulse; rresp=SLVERR with rdata=0.
- Backpressure:
  - Stimulus: hold bready=0 and rready=0 for 5 cycles.
  - Required: bvalid/bresp and rvalid/rdata stay stable, awready/wready/arready stay 0, and each completes on the first ready cycle.
- Concurrency and reset:
  - Stimulus: an AR to reg 3 on the same edge as a commit to reg 3 (old value 0x5, new value 0x7); then a reset during WR_RESP.
  - Required: the read returns 0x5; after the reset, bvalid=0 and all registers are 0.
